// File: rtl/vga_plot_pkg.sv
// Shared constants for the VGA pixel-plot path: frame geometry, field widths,
// plotter state encoding and a basic 3-bit colour palette.
package vga_plot_pkg;

  localparam int SCREEN_W     = 160;
  localparam int SCREEN_H     = 120;
  localparam int X_WIDTH      = 8;
  localparam int Y_WIDTH      = 7;
  localparam int COLOUR_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [COLOUR_WIDTH-1:0] BLACK = 3'b000;
  localparam logic [COLOUR_WIDTH-1:0] RED   = 3'b100;
  localparam logic [COLOUR_WIDTH-1:0] GREEN = 3'b010;
  localparam logic [COLOUR_WIDTH-1:0] BLUE  = 3'b001;
  localparam logic [COLOUR_WIDTH-1:0] WHITE = 3'b111;

endpackage

// File: rtl/raster_scan_counter.sv
// Raster-order (x, y) scan generator over a loaded rectangle; x wraps to the
// left edge and carries into y. Holds on the last pixel until reloaded.
module raster_scan_counter #(
  parameter int X_WIDTH = 8,
  parameter int Y_WIDTH = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [X_WIDTH-1:0] x_start,
  input  logic [Y_WIDTH-1:0] y_start,
  input  logic [X_WIDTH-1:0] x_stop,
  input  logic [Y_WIDTH-1:0] y_stop,
  output logic [X_WIDTH-1:0] x,
  output logic [Y_WIDTH-1:0] y,
  output logic               last
);

  logic [X_WIDTH-1:0] x0_q;
  logic [X_WIDTH-1:0] x_end_q;
  logic [Y_WIDTH-1:0] y_end_q;

  assign last = (x == x_end_q) && (y == y_end_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  // NOTE: the bound registers are reset too; they are only a few flops and
  // a defined value keeps `last` clean straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x       <= '0;
      y       <= '0;
      x0_q    <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
    end else if (load) begin
      x       <= x_start;
      y       <= y_start;
      x0_q    <= x_start;
      x_end_q <= x_stop;
      y_end_q <= y_stop;
    end else if (step && !last) begin
      if (x == x_end_q) begin
        x <= x0_q;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rect_fill_plotter.sv
// Rectangle-fill / clear-screen pixel writer for the vga_adapter: clips the
// request to the frame and streams one registered pixel write per clock.
module rect_fill_plotter #(
  parameter int X_WIDTH      = 8,
  parameter int Y_WIDTH      = 7,
  parameter int COLOUR_WIDTH = 3,
  parameter int SCREEN_W     = 160,
  parameter int SCREEN_H     = 120
) (
  input  logic                    CLOCK_50,
  input  logic                    resetn,
  input  logic                    start,
  input  logic                    clear,
  input  logic [X_WIDTH-1:0]      rect_x,
  input  logic [Y_WIDTH-1:0]      rect_y,
  input  logic [X_WIDTH-1:0]      rect_w,
  input  logic [Y_WIDTH-1:0]      rect_h,
  input  logic [COLOUR_WIDTH-1:0] rect_colour,
  output logic                    busy,
  output logic                    done,
  output logic [X_WIDTH-1:0]      x,
  output logic [Y_WIDTH-1:0]      y,
  output logic [COLOUR_WIDTH-1:0] colour,
  output logic                    plot
);

  import vga_plot_pkg::*;

  state_t state, next_state;

  logic               load;
  logic               last;
  logic [X_WIDTH-1:0] ld_x0, ld_x_end;
  logic [Y_WIDTH-1:0] ld_y0, ld_y_end;

  // Clipping is done one bit wider so x+w-1 / y+h-1 cannot wrap.
  logic [X_WIDTH:0]   x_sum;
  logic [Y_WIDTH:0]   y_sum;
  logic [X_WIDTH-1:0] x_end_clip;
  logic [Y_WIDTH-1:0] y_end_clip;
  logic               empty_req;

  assign x_sum = {1'b0, rect_x} + {1'b0, rect_w} - (X_WIDTH+1)'(1);
  assign y_sum = {1'b0, rect_y} + {1'b0, rect_h} - (Y_WIDTH+1)'(1);

  assign x_end_clip = (x_sum > (X_WIDTH+1)'(SCREEN_W-1)) ? X_WIDTH'(SCREEN_W-1)
                                                         : x_sum[X_WIDTH-1:0];
  assign y_end_clip = (y_sum > (Y_WIDTH+1)'(SCREEN_H-1)) ? Y_WIDTH'(SCREEN_H-1)
                                                         : y_sum[Y_WIDTH-1:0];

  assign empty_req = (rect_w == '0) || (rect_h == '0) ||
                     ({1'b0, rect_x} >= (X_WIDTH+1)'(SCREEN_W)) ||
                     ({1'b0, rect_y} >= (Y_WIDTH+1)'(SCREEN_H));

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    ld_x0      = '0;
    ld_y0      = '0;
    ld_x_end   = '0;
    ld_y_end   = '0;
    case (state)
      IDLE: begin
        if (clear) begin
          next_state = FILL;
          load       = 1'b1;
          ld_x_end   = X_WIDTH'(SCREEN_W-1);
          ld_y_end   = Y_WIDTH'(SCREEN_H-1);
        end else if (start) begin
          if (empty_req) begin
            next_state = DONE;
          end else begin
            next_state = FILL;
            load       = 1'b1;
            ld_x0      = rect_x;
            ld_y0      = rect_y;
            ld_x_end   = x_end_clip;
            ld_y_end   = y_end_clip;
          end
        end
      end
      FILL:    if (last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Status outputs are registered from next_state so they line up with the
  // scan registers, which load on the same accepting edge.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      colour <= '0;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= next_state;
      plot  <= (next_state == FILL);
      busy  <= (next_state != IDLE);
      done  <= (next_state == DONE);
      if (load) colour <= rect_colour;
    end
  end

  raster_scan_counter #(
    .X_WIDTH (X_WIDTH),
    .Y_WIDTH (Y_WIDTH)
  ) u_scan (
    .clk     (CLOCK_50),
    .rst_n   (resetn),
    .load    (load),
    .step    (state == FILL),
    .x_start (ld_x0),
    .y_start (ld_y0),
    .x_stop  (ld_x_end),
    .y_stop  (ld_y_end),
    .x       (x),
    .y       (y),
    .last    (last)
  );

endmodule
